// File: rtl/uart_rx_seq_pkg.sv
// Shared types and default sizing for the UART receive sequencer.
package uart_rx_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // IDLE: nothing pending; IRQ: head byte offered to the CPU; GAP: one low cycle between bytes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rx_seq_fifo.sv
// Byte FIFO for the UART receive sequencer: array storage (no reset needed),
// wrapping read/write pointers and an occupancy counter. A push while full
// is accepted only when a pop happens on the same edge.
module uart_rx_seq_fifo
  import uart_rx_seq_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_reg;
  // Head is read straight from the array so it is valid as soon as level is nonzero
  assign head    = mem[rd_ptr_reg];

  // Storage write; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: buffers received bytes and hands them to the CPU one
// at a time through a registered interrupt with a one-cycle low gap between
// bytes. Tracks a sticky overflow flag for dropped bytes.
// Optional feature: define UART_RX_SEQ_DROP_CNT_EN to build the saturating
// dropped-byte counter; otherwise drop_cnt is tied to zero.
module uart_rx_sequencer
  import uart_rx_seq_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_byte,
  output logic                     int0,
  output logic [DATA_W-1:0]        uart_to_cpu,
  input  logic                     cpu_end_read,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               drop_cnt
);

  state_t state_reg;
  state_t state_next;
  logic   pop;
  logic   drop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   int0_reg;
  logic   overflow_reg;
  logic   overflow_next;

  uart_rx_seq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_byte),
    .head  (uart_to_cpu),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A byte is lost only when the FIFO is full and no pop frees a slot this edge
  assign drop = rx_valid && fifo_full && !pop;

  // Next-state logic; the CPU strobe only matters while the interrupt is up
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = IRQ;
      end
      IRQ: begin
        if (cpu_end_read) begin
          pop        = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = fifo_empty ? IDLE : IRQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered interrupt (high exactly while in IRQ)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      int0_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      int0_reg  <= (state_next == IRQ);
    end
  end

  assign int0 = int0_reg;

  // Sticky overflow: a new drop takes priority over a coincident clear
  always_comb begin
    overflow_next = overflow_reg;
    if (drop)         overflow_next = 1'b1;
    else if (clr_ovf) overflow_next = 1'b0;
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_reg <= 1'b0;
    else      overflow_reg <= overflow_next;
  end

  assign overflow = overflow_reg;

`ifdef UART_RX_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  logic [7:0] drop_cnt_next;

  // Saturating drop counter; a drop wins over a coincident clear
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop) begin
      if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
    end else if (clr_ovf) begin
      drop_cnt_next = 8'd0;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_reg <= 8'd0;
    else      drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule
